// File: rtl/spi_data_shifter.sv
// -----------------------------------------------------------------------------
// spi_data_shifter
//   Data path for the SPI slave control block. Holds the BIT_LENGTH shift
//   register, a one-word TX holding buffer and an RX output register, each with
//   a valid/ready handshake. Flags sticky TX underrun and RX overrun.
//
//   Build option: define SPI_DATA_LSB_FIRST_EN to shift LSB first
//   (bit 0 first on the wire). Default build shifts MSB first.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   ss                slave select (active low, already synchronised)
//   shift_en          1-cycle pulse: shift one bit
//   mosi_bit          received bit from the control block
//   transaction_done  1-cycle pulse: BIT_LENGTH bits received
//   miso_bit          bit to transmit (combinational from the shift register)
//   tx_data/valid/ready   TX word handshake (tx_ready = TX buffer empty)
//   rx_data/valid/ready   RX word handshake
//   status_clr        clears sticky underrun/overrun
//   underrun          sticky: transaction started with no TX word
//   overrun           sticky: received word dropped, RX register still full
// -----------------------------------------------------------------------------
module spi_data_shifter #(
    parameter int unsigned BIT_LENGTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ss,
    input  logic                  shift_en,
    input  logic                  mosi_bit,
    input  logic                  transaction_done,
    output logic                  miso_bit,
    input  logic [BIT_LENGTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [BIT_LENGTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  status_clr,
    output logic                  underrun,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BIT_LENGTH-1:0] r_shreg;
    logic [BIT_LENGTH-1:0] w_shreg_nxt;
    logic [BIT_LENGTH-1:0] w_shifted;
    logic [BIT_LENGTH-1:0] w_shreg_post;
    logic [BIT_LENGTH-1:0] r_tx_buf;
    logic [BIT_LENGTH-1:0] w_tx_buf_nxt;
    logic                  r_tx_full;
    logic                  w_tx_full_nxt;
    logic [BIT_LENGTH-1:0] r_rx_data;
    logic [BIT_LENGTH-1:0] w_rx_data_nxt;
    logic                  r_rx_valid;
    logic                  w_rx_valid_nxt;
    logic                  r_underrun;
    logic                  r_overrun;
    logic                  w_underrun_set;
    logic                  w_overrun_set;
    logic                  w_capture;
    logic                  w_tx_accept;

    // Wire order of the shift register
`ifdef SPI_DATA_LSB_FIRST_EN
    assign w_shifted = {mosi_bit, r_shreg[BIT_LENGTH-1:1]};
    assign miso_bit  = r_shreg[0];
`else
    assign w_shifted = {r_shreg[BIT_LENGTH-2:0], mosi_bit};
    assign miso_bit  = r_shreg[BIT_LENGTH-1];
`endif

    assign w_tx_accept = tx_valid && !r_tx_full;
    assign tx_ready    = !r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;

    // Next-state, shift register and TX buffer
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_shreg_post   = r_shreg;
        w_tx_buf_nxt   = r_tx_buf;
        w_tx_full_nxt  = r_tx_full;
        w_underrun_set = 1'b0;
        w_capture      = 1'b0;

        if (w_tx_accept) begin
            w_tx_buf_nxt  = tx_data;
            w_tx_full_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!ss) begin
                    w_state_nxt = ST_ACTIVE;
                    if (r_tx_full) begin
                        w_shreg_nxt   = r_tx_buf;
                        w_tx_full_nxt = 1'b0;
                    end else if (tx_valid) begin
                        // Bypass: word offered at transaction start goes straight to shreg
                        w_shreg_nxt   = tx_data;
                        w_tx_buf_nxt  = r_tx_buf;
                        w_tx_full_nxt = 1'b0;
                    end else begin
                        w_shreg_nxt    = '0;
                        w_underrun_set = 1'b1;
                    end
                end else if (r_tx_full) begin
                    // Preload so the first MISO bit is ready before ss falls
                    w_shreg_nxt   = r_tx_buf;
                    w_tx_full_nxt = 1'b0;
                    w_state_nxt   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!ss) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (shift_en) begin
                    w_shreg_post = w_shifted;
                end
                if (transaction_done) begin
                    w_capture   = 1'b1;
                    w_shreg_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (ss) begin
                    // Abort: discard partial word, keep tx_buf
                    w_shreg_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_shreg_nxt = w_shreg_post;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RX register and handshake
    always_comb begin
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = r_rx_valid;
        w_overrun_set  = 1'b0;

        if (w_capture) begin
            if (!r_rx_valid || rx_ready) begin
                w_rx_data_nxt  = w_shreg_post;
                w_rx_valid_nxt = 1'b1;
            end else begin
                w_overrun_set = 1'b1;
            end
        end else if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end
    end

    // State registers; sticky flags favour a set event over status_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
            r_tx_full  <= w_tx_full_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_underrun <= w_underrun_set | (r_underrun & ~status_clr);
            r_overrun  <= w_overrun_set | (r_overrun & ~status_clr);
        end
    end

endmodule

// File: tb/tb_spi_data_shifter.sv
`timescale 1ns/1ps
module tb_spi_data_shifter;

    localparam int unsigned W = 32;
`ifdef SPI_DATA_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         ss;
    logic         shift_en;
    logic         mosi_bit;
    logic         transaction_done;
    logic         miso_bit;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         status_clr;
    logic         underrun;
    logic         overrun;

    int total = 0;
    int bad   = 0;

    // Scoreboard: TX words in the order they should appear on MISO, RX words expected out
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    logic         m_rx_full;
    logic         m_under;
    logic         m_over;

    spi_data_shifter #(.BIT_LENGTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .ss               (ss),
        .shift_en         (shift_en),
        .mosi_bit         (mosi_bit),
        .transaction_done (transaction_done),
        .miso_bit         (miso_bit),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .status_clr       (status_clr),
        .underrun         (underrun),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wire position of the i-th transmitted bit
    function automatic int bidx(input int i);
        return LSB_FIRST ? i : (W - 1 - i);
    endfunction

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_rx_full = 1'b0;
        m_under   = 1'b0;
        m_over    = 1'b0;
    endtask

    task automatic load_tx(input logic [W-1:0] w);
        int n;
        @(negedge clk);
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_tx_ready: tx_ready=%b required 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = w;
        txq.push_back(w);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic run_txn(input string nm, input logic [W-1:0] mosi_w, input int nbits,
                           input bit do_done, input bit rdy, input bit byp,
                           input logic [W-1:0] byp_w);
        logic [W-1:0] got;
        logic [W-1:0] exp_w;
        logic [W-1:0] exp_rx;
        got = '0;
        @(negedge clk);
        ss = 1'b0;
        if (byp) begin
            tx_valid = 1'b1;
            tx_data  = byp_w;
            if (txq.size() == 0) txq.push_back(byp_w);
        end
        if (txq.size() != 0) begin
            exp_w = txq.pop_front();
        end else begin
            exp_w   = '0;
            m_under = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            tx_valid         = 1'b0;
            got[bidx(i)]     = miso_bit;
            shift_en         = 1'b1;
            mosi_bit         = mosi_w[bidx(i)];
            if (i == nbits - 1) begin
                ss = 1'b1;
                if (do_done) begin
                    transaction_done = 1'b1;
                    rx_ready         = rdy;
                    if (rdy && m_rx_full) begin
                        // Consumer takes the held word on the same edge as the capture
                        exp_rx = rxq.pop_front();
                        total++;
                        if (rx_data !== exp_rx) begin
                            bad++;
                            $display("FAIL %s_rx_at_done: rx_data=%h required %h", nm, rx_data, exp_rx);
                        end
                    end
                    if (!m_rx_full || rdy) begin
                        rxq.push_back(mosi_w);
                        m_rx_full = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        shift_en         = 1'b0;
        transaction_done = 1'b0;
        rx_ready         = 1'b0;
        mosi_bit         = 1'b0;
        if (nbits == W) begin
            total++;
            if (got !== exp_w) begin
                bad++;
                $display("FAIL %s_miso: observed=%h required %h", nm, got, exp_w);
            end
        end
        total++;
        if (underrun !== m_under) begin
            bad++;
            $display("FAIL %s_underrun: underrun=%b required %b", nm, underrun, m_under);
        end
        total++;
        if (overrun !== m_over) begin
            bad++;
            $display("FAIL %s_overrun: overrun=%b required %b", nm, overrun, m_over);
        end
        total++;
        if (rx_valid !== m_rx_full) begin
            bad++;
            $display("FAIL %s_rx_valid: rx_valid=%b required %b", nm, rx_valid, m_rx_full);
        end
    endtask

    task automatic drain_rx(input string nm);
        int n;
        logic [W-1:0] exp_rx;
        @(negedge clk);
        rx_ready = 1'b1;
        n = 0;
        while (!rx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_valid !== 1'b1 || rxq.size() == 0) begin
            bad++;
            $display("FAIL %s_drain: rx_valid=%b pending=%0d required valid word", nm, rx_valid, rxq.size());
        end else begin
            exp_rx = rxq.pop_front();
            if (rx_data !== exp_rx) begin
                bad++;
                $display("FAIL %s_drain: rx_data=%h required %h", nm, rx_data, exp_rx);
            end
        end
        @(negedge clk);
        rx_ready  = 1'b0;
        m_rx_full = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain_clear: rx_valid=%b required 0", nm, rx_valid);
        end
    endtask

    task automatic clear_status(input string nm);
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        m_under    = 1'b0;
        m_over     = 1'b0;
        total++;
        if (underrun !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL %s_status_clr: underrun=%b overrun=%b required 0 0", nm, underrun, overrun);
        end
    endtask

    task automatic test_reset();
        load_tx(32'h3C3C_3C3C);
        @(negedge clk);
        ss = 1'b0;
        repeat (5) begin
            @(negedge clk);
            shift_en = 1'b1;
            mosi_bit = 1'b1;
        end
        @(negedge clk);
        shift_en = 1'b0;
        mosi_bit = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({miso_bit, tx_ready, rx_valid, underrun, overrun} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_flags: miso,tx_ready,rx_valid,underrun,overrun=%b required 01000",
                     {miso_bit, tx_ready, rx_valid, underrun, overrun});
        end
        total++;
        if (rx_data !== '0) begin
            bad++;
            $display("FAIL reset_rx_data: rx_data=%h required 0", rx_data);
        end
        ss = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        load_tx(32'hA5A5_0F0F);
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_tx_full: tx_ready=%b required 0", tx_ready);
        end
        @(negedge clk);
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_armed: tx_ready=%b required 1", tx_ready);
        end
        run_txn("basic", 32'hDEAD_BEEF, W, 1'b1, 1'b0, 1'b0, '0);
        total++;
        if (rxq.size() == 0 || rx_data !== rxq[0]) begin
            bad++;
            $display("FAIL basic_rx_data: rx_data=%h required %h", rx_data, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_underrun();
        run_txn("underrun", 32'h5555_AAAA, W, 1'b0, 1'b0, 1'b0, '0);
        clear_status("underrun");
    endtask

    task automatic test_overrun();
        load_tx(32'h0F1E_2D3C);
        run_txn("overrun", 32'h1234_5678, W, 1'b1, 1'b0, 1'b0, '0);
        total++;
        if (rxq.size() == 0 || rx_data !== rxq[0]) begin
            bad++;
            $display("FAIL overrun_rx_kept: rx_data=%h required %h", rx_data, 32'hDEAD_BEEF);
        end
        clear_status("overrun");
        drain_rx("overrun");
    endtask

    task automatic test_abort();
        load_tx(32'h77AA_33CC);
        load_tx(32'hCAFE_F00D);
        run_txn("abort", 32'hFFFF_0000, 10, 1'b0, 1'b0, 1'b0, '0);
        run_txn("after_abort", 32'h0BAD_C0DE, W, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_simultaneous();
        load_tx(32'h5A5A_5A5A);
        run_txn("simul", 32'h600D_F00D, W, 1'b1, 1'b1, 1'b0, '0);
        drain_rx("simul");
    endtask

    task automatic test_back_to_back();
        run_txn("bypass1", 32'h2468_ACE0, W, 1'b1, 1'b0, 1'b1, 32'h1357_9BDF);
        run_txn("bypass2", 32'h8000_0001, W, 1'b1, 1'b1, 1'b1, 32'hFEDC_BA98);
        drain_rx("bypass2");
    endtask

    initial begin
        reset            = 1'b1;
        ss               = 1'b1;
        shift_en         = 1'b0;
        mosi_bit         = 1'b0;
        transaction_done = 1'b0;
        tx_data          = '0;
        tx_valid         = 1'b0;
        rx_ready         = 1'b0;
        status_clr       = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_abort();
        test_simultaneous();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
